// File: rtl/urv_irq_arbiter.sv
// External-interrupt arbiter: synchronises N_IRQ sources, latches edges or follows levels,
// masks with ENABLE, presents the lowest-index request to the core on exp_irq_o, and runs
// a single-outstanding claim/complete handshake over a 4-word register bus (1-cycle ack).
module urv_irq_arbiter #(
  parameter int               N_IRQ     = 8,
  parameter logic [N_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [1:0]       reg_addr_i,
  input  logic             reg_we_i,
  input  logic             reg_re_i,
  input  logic [31:0]      reg_wdata_i,
  output logic [31:0]      reg_rdata_o,
  output logic             reg_ack_o,
  output logic             exp_irq_o,
  output logic [4:0]       irq_id_o
);

  localparam logic [1:0] ADDR_PENDING  = 2'd0;
  localparam logic [1:0] ADDR_ENABLE   = 2'd1;
  localparam logic [1:0] ADDR_CLAIM    = 2'd2;
  localparam logic [1:0] ADDR_COMPLETE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Synchroniser chain; s3 is a one-cycle delay of s2 used only for rising-edge detection.
  logic [N_IRQ-1:0] s1_q, s1_d;
  logic [N_IRQ-1:0] s2_q, s2_d;
  logic [N_IRQ-1:0] s3_q, s3_d;

  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] en_q, en_d;
  logic [4:0]       id_q, id_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ack_q, ack_d;

  logic [N_IRQ-1:0] req;
  logic             has_req;
  logic [4:0]       win_id;
  logic             claim_hit;
  logic             complete_hit;
  logic             pend_wr;
  logic             en_wr;
  logic [31:0]      rd_val;

  // Upper write-data bits beyond the source count carry no meaning here.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata_i;

  // Masked request vector and lowest-index winner (scan downwards so the lowest set bit wins).
  always_comb begin
    req     = pend_q & en_q;
    has_req = |req;
    win_id  = 5'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_id = 5'(i);
      end
    end
  end

  // Bus decode. A simultaneous write suppresses the claim side effect of a read.
  always_comb begin
    claim_hit    = reg_re_i && !reg_we_i && (reg_addr_i == ADDR_CLAIM)
                   && (state_q == ST_REQ) && has_req;
    complete_hit = reg_we_i && (reg_addr_i == ADDR_COMPLETE)
                   && (state_q == ST_SERVICE) && (reg_wdata_i[4:0] == id_q);
    pend_wr      = reg_we_i && (reg_addr_i == ADDR_PENDING);
    en_wr        = reg_we_i && (reg_addr_i == ADDR_ENABLE);
  end

  // Read mux; a claim that does not hit returns zero with bit 31 clear.
  always_comb begin
    rd_val = 32'd0;
    case (reg_addr_i)
      ADDR_PENDING:  rd_val = 32'(pend_q);
      ADDR_ENABLE:   rd_val = 32'(en_q);
      ADDR_CLAIM:    rd_val = claim_hit ? {1'b1, 26'd0, win_id} : 32'd0;
      ADDR_COMPLETE: rd_val = 32'd0;
      default:       rd_val = 32'd0;
    endcase
  end

  // Next-state for the datapath: sync chain, pending, enable, in-service id and bus response.
  always_comb begin
    s1_d = irq_i;
    s2_d = s1_q;
    s3_d = s2_q;

    for (int i = 0; i < N_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        // A new edge in the same cycle as a clear must not be lost, so set dominates.
        pend_d[i] = (s2_q[i] & ~s3_q[i])
                    | (pend_q[i] & ~((claim_hit && (win_id == 5'(i)))
                                     || (pend_wr && reg_wdata_i[i])));
      end else begin
        pend_d[i] = s2_q[i];
      end
    end

    en_d = en_wr ? reg_wdata_i[N_IRQ-1:0] : en_q;

    id_d = id_q;
    if (claim_hit) begin
      id_d = win_id;
    end else if (complete_hit) begin
      id_d = 5'd0;
    end

    ack_d   = reg_re_i || reg_we_i;
    rdata_d = reg_re_i ? rd_val : 32'd0;
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      id_q    <= 5'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      id_q    <= id_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: request, claim into service, release on matching complete.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (has_req) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (claim_hit) begin
          state_d = ST_SERVICE;
        end else if (!has_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (complete_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the core is only interrupted while a request waits to be claimed.
  always_comb begin
    exp_irq_o = (state_q == ST_REQ);
  end

  assign reg_rdata_o = rdata_q;
  assign reg_ack_o   = ack_q;
  assign irq_id_o    = id_q;

endmodule

// File: tb/tb_urv_irq_arbiter.sv
// Bench for urv_irq_arbiter: directed scenarios plus randomized traffic, with every cycle
// compared against a behavioural model (history of sampled inputs, per-source pending rules,
// and a three-phase view of the handshake).
module tb_urv_irq_arbiter;

  localparam int         N  = 8;
  localparam logic [7:0] EM = 8'h05;  // sources 0 and 2 edge-triggered, others level

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = 8'h00;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ack;
  logic        exp_irq;
  logic [4:0]  irq_id;

  urv_irq_arbiter #(.N_IRQ(N), .EDGE_MASK(EM)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .irq_i      (irq),
    .reg_addr_i (addr),
    .reg_we_i   (we),
    .reg_re_i   (re),
    .reg_wdata_i(wdata),
    .reg_rdata_o(rdata),
    .reg_ack_o  (ack),
    .exp_irq_o  (exp_irq),
    .irq_id_o   (irq_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[k] = irq sampled k+1 edges ago; phase 0 = quiet, 1 = asking the core, 2 = claimed.
  logic [7:0]  hist [3];
  logic [7:0]  m_pend, m_en;
  int          m_phase;
  logic [4:0]  m_id;
  logic        m_ack;
  logic [31:0] m_rdata;

  task automatic model_step();
    logic [7:0]  rq;
    logic [7:0]  np;
    int          win;
    logic        claim;
    logic [31:0] rd;
    if (rst) begin
      for (int k = 0; k < 3; k++) hist[k] = 8'h00;
      m_pend = 8'h00; m_en = 8'h00; m_phase = 0; m_id = 5'd0;
      m_ack = 1'b0; m_rdata = 32'd0;
    end else begin
      rq  = m_pend & m_en;
      win = -1;
      for (int i = 0; i < N; i++) if (rq[i] && win < 0) win = i;
      claim = re && !we && addr == 2'd2 && m_phase == 1 && win >= 0;
      case (addr)
        2'd0:    rd = {24'd0, m_pend};
        2'd1:    rd = {24'd0, m_en};
        2'd2:    rd = claim ? (32'h8000_0000 | 32'(win)) : 32'd0;
        default: rd = 32'd0;
      endcase
      m_ack   = re || we;
      m_rdata = re ? rd : 32'd0;
      for (int i = 0; i < N; i++) begin
        if (EM[i])
          np[i] = (hist[1][i] && !hist[2][i]) ||
                  (m_pend[i] && !((claim && win == i) || (we && addr == 2'd0 && wdata[i])));
        else
          np[i] = hist[1][i];
      end
      case (m_phase)
        0: if (win >= 0) m_phase = 1;
        1: begin
          if (claim) begin m_phase = 2; m_id = 5'(win); end
          else if (win < 0) m_phase = 0;
        end
        default: if (we && addr == 2'd3 && wdata[4:0] == m_id) begin m_phase = 0; m_id = 5'd0; end
      endcase
      if (we && addr == 2'd1) m_en = wdata[7:0];
      m_pend  = np;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = irq;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (mon_en) begin
      check("m_exp_irq", {31'd0, exp_irq}, {31'd0, m_phase == 1});
      check("m_irq_id", {27'd0, irq_id}, {27'd0, m_id});
      check("m_ack", {31'd0, ack}, {31'd0, m_ack});
      check("m_rdata", rdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_exp(input logic val, input int budget, input string tag);
    int k;
    k = 0;
    while (exp_irq !== val && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, exp_irq}, {31'd0, val});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int r;

    // 1: reset with all sources high and nothing enabled
    rst = 1'b1; irq = 8'hFF;
    @(negedge clk); @(negedge clk);
    mon_en = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t1_exp", {31'd0, exp_irq}, 32'd0);
      check("t1_ack", {31'd0, ack}, 32'd0);
      check("t1_id", {27'd0, irq_id}, 32'd0);
    end
    irq = 8'h00;
    cycles(4);
    bus_wr(2'd0, 32'hFF);
    cycles(2);
    bus_rd(2'd0, d);
    check("t1_pend_clr", d, 32'd0);

    // 2: one-cycle pulse on edge source 2
    bus_wr(2'd1, 32'h0C);
    irq = 8'h04;
    @(negedge clk); irq = 8'h00;
    check("t2_edge1", {31'd0, exp_irq}, 32'd0);
    @(negedge clk); check("t2_edge2", {31'd0, exp_irq}, 32'd0);
    @(negedge clk); check("t2_edge3", {31'd0, exp_irq}, 32'd0);
    @(negedge clk); check("t2_edge4", {31'd0, exp_irq}, 32'd1);
    bus_rd(2'd2, d);
    check("t2_claim", d, 32'h8000_0002);
    check("t2_exp_drop", {31'd0, exp_irq}, 32'd0);
    bus_rd(2'd0, d);
    check("t2_pend", d, 32'd0);
    check("t2_id", {27'd0, irq_id}, 32'd2);
    bus_wr(2'd3, 32'd2);
    check("t2_id_clr", {27'd0, irq_id}, 32'd0);
    cycles(3);
    check("t2_idle", {31'd0, exp_irq}, 32'd0);

    // 3: two level sources, mismatched complete, re-request
    bus_wr(2'd1, 32'hFF);
    irq = 8'h28;
    wait_exp(1'b1, 10, "t3_req");
    bus_rd(2'd2, d);
    check("t3_claim", d, 32'h8000_0003);
    bus_wr(2'd3, 32'd5);
    check("t3_bad_cpl", {27'd0, irq_id}, 32'd3);
    bus_wr(2'd3, 32'd3);
    check("t3_cpl", {27'd0, irq_id}, 32'd0);
    wait_exp(1'b1, 4, "t3_rereq");
    bus_rd(2'd2, d);
    check("t3_claim2", d, 32'h8000_0003);
    bus_wr(2'd3, 32'd3);
    irq = 8'h00;
    cycles(6);

    // 4: level request withdrawn before the claim
    irq = 8'h02;
    wait_exp(1'b1, 10, "t4_req");
    irq = 8'h00;
    cycles(5);
    check("t4_exp_fall", {31'd0, exp_irq}, 32'd0);
    bus_rd(2'd2, d);
    check("t4_claim", d, 32'd0);
    check("t4_id", {27'd0, irq_id}, 32'd0);

    // 5: new edge on source 0 coincides with a PENDING clear
    bus_wr(2'd1, 32'd0);
    irq = 8'h01; cycles(4);
    irq = 8'h00; cycles(4);
    bus_rd(2'd0, d);
    check("t5_pre", d, 32'h1);
    irq = 8'h01;
    @(negedge clk); @(negedge clk);
    bus_wr(2'd0, 32'h1);
    bus_rd(2'd0, d);
    check("t5_set_wins", d, 32'h1);
    bus_wr(2'd0, 32'h1);
    bus_rd(2'd0, d);
    check("t5_clr", d, 32'h0);
    irq = 8'h00;
    cycles(4);

    // simultaneous read and write: one ack, write lands
    addr = 2'd1; wdata = 32'hFFFF_FF33; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    check("rw_ack", {31'd0, ack}, 32'd1);
    @(negedge clk);
    check("rw_ack_once", {31'd0, ack}, 32'd0);
    bus_rd(2'd1, d);
    check("rw_enable", d, 32'h33);
    bus_rd(2'd3, d);
    check("cpl_read", d, 32'd0);

    // 6: reset while in service
    bus_wr(2'd1, 32'h10);
    irq = 8'h10;
    wait_exp(1'b1, 10, "t6_req");
    bus_rd(2'd2, d);
    check("t6_claim", d, 32'h8000_0004);
    check("t6_id", {27'd0, irq_id}, 32'd4);
    rst = 1'b1; irq = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    check("t6_exp", {31'd0, exp_irq}, 32'd0);
    check("t6_id_rst", {27'd0, irq_id}, 32'd0);
    check("t6_ack", {31'd0, ack}, 32'd0);
    check("t6_rdata", rdata, 32'd0);
    bus_rd(2'd2, d);
    check("t6_claim_empty", d, 32'd0);

    // randomized traffic against the model
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 7) == 0) irq = 8'($urandom);
      re = 1'b0; we = 1'b0;
      r = $urandom_range(0, 11);
      if (r < 2) begin
        re = 1'b1; addr = 2'd2;
      end else if (r < 4) begin
        re = 1'b1; addr = 2'($urandom_range(0, 3));
      end else if (r == 4) begin
        we = 1'b1; addr = 2'd3;
        wdata = ($urandom_range(0, 1) == 1) ? {27'd0, m_id} : 32'($urandom_range(0, 31));
      end else if (r == 5) begin
        we = 1'b1; addr = 2'($urandom_range(0, 1)); wdata = $urandom;
      end else if (r == 6) begin
        we = 1'b1; re = 1'b1; addr = 2'($urandom_range(0, 3)); wdata = $urandom;
      end
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    re = 1'b0; we = 1'b0; rst = 1'b0;
    cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
